// File: rtl/sdram_slot_arbiter_pkg.sv
// Shared definitions for the SDRAM slot arbiter: bus widths, slot timing helpers
// and the per-slot command encoding.
package sdram_slot_arbiter_pkg;

  localparam int unsigned ADDR_W       = 24;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned BE_W         = 2;
  localparam int unsigned SLOT_LEN_DEF = 8;
  localparam int unsigned GRANT_PHASE  = 1;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_RD   = 2'd1,
    CMD_WR   = 2'd2
  } cmd_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } port_cmd_t;

  function automatic int unsigned phase_w(input int unsigned slot_len);
    return (slot_len > 1) ? $clog2(slot_len) : 1;
  endfunction

  // Reference strobe is high for the first half of every slot.
  function automatic int unsigned clkref_high_phases(input int unsigned slot_len);
    return slot_len / 2;
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: first eligible port after ptr, wrapping.
module sdram_rr_pick
  import sdram_slot_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 valid_c,
  output logic [IDX_W-1:0]     index_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid_c = 1'b0;
    index_c = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_PORTS);
      if (!valid_c && eligible[cand]) begin
        valid_c = 1'b1;
        index_c = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// Fixed-slot arbiter sharing one SDRAM controller between NUM_PORTS requesters,
// with an init blackout window and forced idle slots for auto-refresh.
module sdram_slot_arbiter
  import sdram_slot_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 3,
  parameter int unsigned SLOT_LEN    = SLOT_LEN_DEF,
  parameter int unsigned INIT_SLOTS  = 32,
  parameter int unsigned REFRESH_MAX = 6
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [ADDR_W*NUM_PORTS-1:0] addr,
  input  logic [DATA_W*NUM_PORTS-1:0] wdata,
  input  logic [BE_W*NUM_PORTS-1:0]   be,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_clkref,
  output logic                        mem_rd,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_raddr,
  output logic [ADDR_W-1:0]           mem_waddr,
  output logic [DATA_W-1:0]           mem_din,
  output logic [BE_W-1:0]             mem_be,
  input  logic [DATA_W-1:0]           mem_dout
);

  localparam int unsigned PH_W   = phase_w(SLOT_LEN);
  localparam int unsigned CLK_HI = clkref_high_phases(SLOT_LEN);
  localparam int unsigned IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned INIT_W = (INIT_SLOTS > 0) ? $clog2(INIT_SLOTS + 1) : 1;
  localparam int unsigned BUSY_W = (REFRESH_MAX > 0) ? $clog2(REFRESH_MAX + 1) : 1;

  logic [PH_W-1:0]      phase_q, phase_d;
  logic                 clkref_q, clkref_d;
  logic [INIT_W-1:0]    init_q, init_d;
  logic [BUSY_W-1:0]    busy_q, busy_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     port_q, port_d;
  cmd_e                 cmd_q, cmd_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    raddr_q, raddr_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [DATA_W-1:0]    din_q, din_d;
  logic [BE_W-1:0]      be_q, be_d;

  logic [NUM_PORTS-1:0] done_mask_c;
  logic [NUM_PORTS-1:0] eligible_c;
  logic                 pick_valid_c;
  logic [IDX_W-1:0]     pick_idx_c;
  port_cmd_t            sel_c;
  logic                 grant_pt_c;
  logic                 suppress_c;

  // The port completing this slot sits out one grant point.
  always_comb begin
    done_mask_c = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if ((cmd_q != CMD_IDLE) && (port_q == IDX_W'(i))) done_mask_c[i] = 1'b1;
    end
    eligible_c = req & ~done_mask_c;
  end

  sdram_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .eligible (eligible_c),
    .ptr      (ptr_q),
    .valid_c  (pick_valid_c),
    .index_c  (pick_idx_c)
  );

  always_comb begin
    sel_c = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (pick_idx_c == IDX_W'(i)) begin
        sel_c.we    = we[i];
        sel_c.addr  = addr[i*ADDR_W +: ADDR_W];
        sel_c.wdata = wdata[i*DATA_W +: DATA_W];
        sel_c.be    = be[i*BE_W +: BE_W];
      end
    end
  end

  // Slot sequencing, completion, grant and bus drive.
  always_comb begin
    phase_d = phase_q + PH_W'(1);
    if (phase_q == PH_W'(SLOT_LEN - 1)) phase_d = '0;
    clkref_d   = (phase_d < PH_W'(CLK_HI));
    grant_pt_c = (phase_d == PH_W'(GRANT_PHASE));
    suppress_c = (init_q != '0) || (busy_q == BUSY_W'(REFRESH_MAX));

    init_d   = init_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    port_d   = port_q;
    cmd_d    = cmd_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    mem_rd_d = mem_rd_q;
    mem_we_d = mem_we_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    din_d    = din_q;
    be_d     = be_q;

    if (grant_pt_c) begin
      ack_d = done_mask_c;
      if (cmd_q == CMD_RD) rdata_d = mem_dout;
      if (init_q != '0) init_d = init_q - INIT_W'(1);

      if (pick_valid_c && !suppress_c) begin
        ptr_d    = pick_idx_c;
        port_d   = pick_idx_c;
        cmd_d    = sel_c.we ? CMD_WR : CMD_RD;
        mem_rd_d = !sel_c.we;
        mem_we_d = sel_c.we;
        if (sel_c.we) begin
          waddr_d = sel_c.addr;
          din_d   = sel_c.wdata;
          be_d    = sel_c.be;
        end else begin
          raddr_d = sel_c.addr;
        end
        if (busy_q != BUSY_W'(REFRESH_MAX)) busy_d = busy_q + BUSY_W'(1);
      end else begin
        cmd_d    = CMD_IDLE;
        mem_rd_d = 1'b0;
        mem_we_d = 1'b0;
        busy_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= '0;
      clkref_q <= 1'b0;
      init_q   <= INIT_W'(INIT_SLOTS);
      busy_q   <= '0;
      ptr_q    <= '0;
      port_q   <= '0;
      cmd_q    <= CMD_IDLE;
      ack_q    <= '0;
      rdata_q  <= '0;
      mem_rd_q <= 1'b0;
      mem_we_q <= 1'b0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      din_q    <= '0;
      be_q     <= '0;
    end else begin
      phase_q  <= phase_d;
      clkref_q <= clkref_d;
      init_q   <= init_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
      port_q   <= port_d;
      cmd_q    <= cmd_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      mem_rd_q <= mem_rd_d;
      mem_we_q <= mem_we_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      din_q    <= din_d;
      be_q     <= be_d;
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign mem_clkref = clkref_q;
  assign mem_rd     = mem_rd_q;
  assign mem_we     = mem_we_q;
  assign mem_raddr  = raddr_q;
  assign mem_waddr  = waddr_q;
  assign mem_din    = din_q;
  assign mem_be     = be_q;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Directed bench for sdram_slot_arbiter: init blackout, slot-by-slot vector table,
// and reset in the middle of a granted read.
module tb_sdram_slot_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req, we;
  logic [71:0] addr;
  logic [47:0] wdata;
  logic [5:0]  be;
  logic [2:0]  ack;
  logic [15:0] rdata;
  logic        mem_clkref, mem_rd, mem_we;
  logic [23:0] mem_raddr, mem_waddr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic [15:0] mem_dout;

  logic [2:0]  tb_phase;
  int          n_chk;
  int          n_fail;

  sdram_slot_arbiter #(
    .NUM_PORTS   (3),
    .SLOT_LEN    (8),
    .INIT_SLOTS  (32),
    .REFRESH_MAX (6)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .be         (be),
    .ack        (ack),
    .rdata      (rdata),
    .mem_clkref (mem_clkref),
    .mem_rd     (mem_rd),
    .mem_we     (mem_we),
    .mem_raddr  (mem_raddr),
    .mem_waddr  (mem_waddr),
    .mem_din    (mem_din),
    .mem_be     (mem_be),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference slot phase: 0 in reset, +1 per clock, 8-clock slots.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_phase <= 3'd0;
    else          tb_phase <= tb_phase + 3'd1;
  end

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic [71:0] addr;
    logic [47:0] wdata;
    logic [5:0]  be;
    logic [15:0] dout;
    logic [2:0]  ack;
    logic        rd;
    logic        wr;
    logic [23:0] raddr;
    logic [23:0] waddr;
    logic [15:0] din;
    logic [1:0]  mbe;
    logic [15:0] rdata;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] w,
                              input logic [23:0] a0, input logic [23:0] a1, input logic [23:0] a2,
                              input logic [15:0] wd2, input logic [1:0] be2, input logic [15:0] dout,
                              input logic [2:0] ek, input logic erd, input logic ewr,
                              input logic [23:0] era, input logic [23:0] ewa,
                              input logic [15:0] edin, input logic [1:0] ebe, input logic [15:0] erdata);
    vec_t v;
    v.req = r;  v.we = w;
    v.addr = {a2, a1, a0};
    v.wdata = {wd2, 16'h0000, 16'h0000};
    v.be = {be2, 2'b00, 2'b00};
    v.dout = dout;
    v.ack = ek; v.rd = erd; v.wr = ewr;
    v.raddr = era; v.waddr = ewa; v.din = edin; v.mbe = ebe; v.rdata = erdata;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic next_grant();
    do begin
      @(posedge clk);
      #1;
    end while (tb_phase != 3'd1);
  endtask

  task automatic check_all_zero(input int idx);
    chk("rst_ack", idx, 32'(ack), 0);
    chk("rst_rdata", idx, 32'(rdata), 0);
    chk("rst_clkref", idx, 32'(mem_clkref), 0);
    chk("rst_rdwe", idx, 32'({mem_rd, mem_we}), 0);
    chk("rst_raddr", idx, 32'(mem_raddr), 0);
    chk("rst_waddr", idx, 32'(mem_waddr), 0);
    chk("rst_din_be", idx, 32'({mem_din, mem_be}), 0);
  endtask

  // 32 blocked slots straight after reset release: no bus activity, no ack.
  task automatic run_init(input int run);
    int ea, eb, ec;
    ea = 0; eb = 0; ec = 0;
    for (int c = 0; c < 256; c++) begin
      @(posedge clk);
      #1;
      if (ack != 3'b000) ea++;
      if (mem_rd || mem_we) eb++;
      if (mem_clkref !== (tb_phase < 3'd4)) ec++;
      if ((c % 8) == 7) begin
        chk("init_ack", run * 100 + c / 8, 32'(ea), 0);
        chk("init_bus", run * 100 + c / 8, 32'(eb), 0);
        chk("init_clkref", run * 100 + c / 8, 32'(ec), 0);
        ea = 0; eb = 0; ec = 0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;

    tbl[0]  = mk(3'b001, 3'b000, 24'hABCDE0, 24'h000000, 24'h000000, 16'h0000, 2'b00, 16'h0000,
                 3'b000, 1'b1, 1'b0, 24'hABCDE0, 24'h000000, 16'h0000, 2'b00, 16'h0000);
    tbl[1]  = mk(3'b011, 3'b000, 24'hABCDE0, 24'h123456, 24'h000000, 16'h0000, 2'b00, 16'h1111,
                 3'b001, 1'b1, 1'b0, 24'h123456, 24'h000000, 16'h0000, 2'b00, 16'h1111);
    tbl[2]  = mk(3'b110, 3'b100, 24'hABCDE0, 24'h123456, 24'h000010, 16'hA55A, 2'b01, 16'hBEEF,
                 3'b010, 1'b0, 1'b1, 24'h123456, 24'h000010, 16'hA55A, 2'b01, 16'hBEEF);
    tbl[3]  = mk(3'b000, 3'b100, 24'hABCDE0, 24'h123456, 24'h000010, 16'hA55A, 2'b01, 16'h5555,
                 3'b100, 1'b0, 1'b0, 24'h123456, 24'h000010, 16'hA55A, 2'b01, 16'hBEEF);
    tbl[4]  = mk(3'b000, 3'b000, 24'h000000, 24'h000000, 24'h000000, 16'h0000, 2'b00, 16'h0000,
                 3'b000, 1'b0, 1'b0, 24'h123456, 24'h000010, 16'hA55A, 2'b01, 16'hBEEF);
    tbl[5]  = mk(3'b111, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h0000,
                 3'b000, 1'b1, 1'b0, 24'h000100, 24'h000010, 16'hA55A, 2'b01, 16'hBEEF);
    tbl[6]  = mk(3'b111, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h0A0A,
                 3'b001, 1'b1, 1'b0, 24'h000101, 24'h000010, 16'hA55A, 2'b01, 16'h0A0A);
    tbl[7]  = mk(3'b111, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h0B0B,
                 3'b010, 1'b1, 1'b0, 24'h000102, 24'h000010, 16'hA55A, 2'b01, 16'h0B0B);
    tbl[8]  = mk(3'b111, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h0C0C,
                 3'b100, 1'b1, 1'b0, 24'h000100, 24'h000010, 16'hA55A, 2'b01, 16'h0C0C);
    tbl[9]  = mk(3'b111, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h0D0D,
                 3'b001, 1'b1, 1'b0, 24'h000101, 24'h000010, 16'hA55A, 2'b01, 16'h0D0D);
    tbl[10] = mk(3'b111, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h0E0E,
                 3'b010, 1'b1, 1'b0, 24'h000102, 24'h000010, 16'hA55A, 2'b01, 16'h0E0E);
    tbl[11] = mk(3'b111, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h0F0F,
                 3'b100, 1'b0, 1'b0, 24'h000102, 24'h000010, 16'hA55A, 2'b01, 16'h0F0F);
    tbl[12] = mk(3'b111, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h1010,
                 3'b000, 1'b1, 1'b0, 24'h000100, 24'h000010, 16'hA55A, 2'b01, 16'h0F0F);
    tbl[13] = mk(3'b011, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h1313,
                 3'b001, 1'b1, 1'b0, 24'h000101, 24'h000010, 16'hA55A, 2'b01, 16'h1313);
    tbl[14] = mk(3'b011, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h1414,
                 3'b010, 1'b1, 1'b0, 24'h000100, 24'h000010, 16'hA55A, 2'b01, 16'h1414);
    tbl[15] = mk(3'b011, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h1515,
                 3'b001, 1'b1, 1'b0, 24'h000101, 24'h000010, 16'hA55A, 2'b01, 16'h1515);
    tbl[16] = mk(3'b011, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h1616,
                 3'b010, 1'b1, 1'b0, 24'h000100, 24'h000010, 16'hA55A, 2'b01, 16'h1616);
    tbl[17] = mk(3'b011, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h1717,
                 3'b001, 1'b1, 1'b0, 24'h000101, 24'h000010, 16'hA55A, 2'b01, 16'h1717);
    tbl[18] = mk(3'b011, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h1818,
                 3'b010, 1'b0, 1'b0, 24'h000101, 24'h000010, 16'hA55A, 2'b01, 16'h1818);
    tbl[19] = mk(3'b011, 3'b000, 24'h000100, 24'h000101, 24'h000102, 16'h0000, 2'b00, 16'h1919,
                 3'b000, 1'b1, 1'b0, 24'h000100, 24'h000010, 16'hA55A, 2'b01, 16'h1818);

    reset_n  = 1'b0;
    req      = 3'b000;
    we       = 3'b000;
    addr     = '0;
    wdata    = '0;
    be       = '0;
    mem_dout = 16'h0000;
    #22;
    check_all_zero(0);

    // Port0 reads from before release; it must stay blocked for the init window.
    req  = 3'b001;
    addr = {24'h000000, 24'h000000, 24'hABCDE0};
    @(negedge clk);
    reset_n = 1'b1;
    run_init(0);

    for (int i = 0; i < NV; i++) begin
      req      = tbl[i].req;
      we       = tbl[i].we;
      addr     = tbl[i].addr;
      wdata    = tbl[i].wdata;
      be       = tbl[i].be;
      mem_dout = tbl[i].dout;
      next_grant();
      chk("ack", i, 32'(ack), 32'(tbl[i].ack));
      chk("mem_rd", i, 32'(mem_rd), 32'(tbl[i].rd));
      chk("mem_we", i, 32'(mem_we), 32'(tbl[i].wr));
      chk("mem_raddr", i, 32'(mem_raddr), 32'(tbl[i].raddr));
      chk("mem_waddr", i, 32'(mem_waddr), 32'(tbl[i].waddr));
      chk("mem_din", i, 32'(mem_din), 32'(tbl[i].din));
      chk("mem_be", i, 32'(mem_be), 32'(tbl[i].mbe));
      chk("rdata", i, 32'(rdata), 32'(tbl[i].rdata));
      @(posedge clk);
      #1;
      chk("ack_pulse", i, 32'(ack), 0);
    end

    // Reset at phase 4 of the read granted in the last table slot.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_phase", 0, 32'(tb_phase), 4);
    reset_n = 1'b0;
    #1;
    check_all_zero(1);
    req  = 3'b001;
    we   = 3'b000;
    addr = {24'h000000, 24'h000000, 24'hABCDE0};
    mem_dout = 16'h7777;
    #30;
    @(negedge clk);
    reset_n = 1'b1;
    run_init(1);

    next_grant();
    chk("restart_rd", 0, 32'(mem_rd), 1);
    chk("restart_raddr", 0, 32'(mem_raddr), 32'h00ABCDE0);
    chk("restart_ack", 0, 32'(ack), 0);
    chk("restart_rdata", 0, 32'(rdata), 0);
    req = 3'b000;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      chk("restart_wait_ack", c, 32'(ack), 0);
    end
    @(posedge clk);
    #1;
    chk("restart_done_ack", 0, 32'(ack), 32'b001);
    chk("restart_done_rdata", 0, 32'(rdata), 32'h7777);
    chk("restart_idle_rd", 0, 32'(mem_rd), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
